// File: rtl/regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Purpose:
//   Arbitrates two writeback producers (req0: decode/ALU results, req1:
//   memory/load returns) onto the single write port of the 32 x 32-bit
//   register file, through one registered stage. Also keeps a per-register
//   busy scoreboard so decode can stall reads of registers whose writeback
//   is still pending.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0_* / req1_*            producer valid/addr/data in, ready out
//   issue_valid/addr/ready     decode marks a destination register pending
//   rd0_ctrl/rd1_ctrl          decode read indices
//   rd0_hazard/rd1_hazard      busy bit of the corresponding read index
//   rf_write/rf_w_ctrl/
//   rf_w_data                  registered register file write port
//   busy_count                 number of busy bits currently set
//
// Handshake: a producer raises reqN_valid with addr/data and holds all three
// stable until reqN_ready is seen high; the transfer happens on the posedge
// where valid & ready are both high. ready never rises without its valid and
// at most one ready is high per cycle. issue_valid/issue_ready behave the
// same way for the scoreboard.
// ---------------------------------------------------------------------------
module regfile_wb_scheduler #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rd0_ctrl,
  input  logic [ADDR_W-1:0] rd1_ctrl,
  output logic              rd0_hazard,
  output logic              rd1_hazard,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_w_ctrl,
  output logic [DATA_W-1:0] rf_w_data,
  output logic [ADDR_W:0]   busy_count
);

  // last_grant_q: 0 = req0 was granted last, 1 = req1 was granted last.
  logic                last_grant_q, last_grant_d;
  logic                grant0, grant1;
  logic                rf_write_q;
  logic [ADDR_W-1:0]   rf_w_ctrl_q, rf_w_ctrl_d;
  logic [DATA_W-1:0]   rf_w_data_q, rf_w_data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     busy_count_q, busy_count_d;
  logic                set_fire, clr_hit;
  logic [NUM_REGS-1:0] set_vec, clr_vec;

  // Round-robin: a sole requester always wins; on a tie the producer that
  // was not granted last wins.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant_q);
    grant1 = req1_valid & (~req0_valid | ~last_grant_q);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    last_grant_d = last_grant_q;
    rf_w_ctrl_d  = rf_w_ctrl_q;
    rf_w_data_d  = rf_w_data_q;
    if (grant0) begin
      last_grant_d = 1'b0;
      rf_w_ctrl_d  = req0_addr;
      rf_w_data_d  = req0_data;
    end else if (grant1) begin
      last_grant_d = 1'b1;
      rf_w_ctrl_d  = req1_addr;
      rf_w_data_d  = req1_data;
    end
  end

  // Scoreboard. A set needs the bit clear (issue_ready) and a clear only
  // counts when the bit is set, so a set and a counted clear never target
  // the same register. That makes the set-wins rule hold automatically and
  // lets busy_count move by at most one per edge.
  assign issue_ready = ~busy_q[issue_addr];
  assign set_fire    = issue_valid & issue_ready;
  assign clr_hit     = rf_write_q & busy_q[rf_w_ctrl_q];

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_fire)   set_vec[issue_addr]  = 1'b1;
    if (rf_write_q) clr_vec[rf_w_ctrl_q] = 1'b1;
    busy_d = (busy_q & ~clr_vec) | set_vec;
  end

  always_comb begin
    busy_count_d = busy_count_q;
    case ({set_fire, clr_hit})
      2'b10:   busy_count_d = busy_count_q + (ADDR_W+1)'(1);
      2'b01:   busy_count_d = busy_count_q - (ADDR_W+1)'(1);
      default: busy_count_d = busy_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      rf_write_q   <= 1'b0;
      rf_w_ctrl_q  <= '0;
      rf_w_data_q  <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_write_q   <= grant0 | grant1;
      rf_w_ctrl_q  <= rf_w_ctrl_d;
      rf_w_data_q  <= rf_w_data_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  // Hazards read the registered busy bits, so a hazard drops the cycle after
  // the edge that commits the write and decode sees the new file contents.
  assign rd0_hazard = busy_q[rd0_ctrl];
  assign rd1_hazard = busy_q[rd1_ctrl];

  assign rf_write   = rf_write_q;
  assign rf_w_ctrl  = rf_w_ctrl_q;
  assign rf_w_data  = rf_w_data_q;
  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_scheduler
//
// Self-checking bench for regfile_wb_scheduler. The driver presents inputs on
// the falling edge, predicts the arbitration winner with its own round-robin
// model and pushes the expected {addr,data} write into exp_q. A monitor pops
// exp_q whenever rf_write is seen high on a falling edge. Scenario tasks also
// check ready, scoreboard and hazard outputs inline.
// ---------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  logic              clk;
  logic              rst_n;
  logic              req0_valid, req1_valid, issue_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr, issue_addr;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready, issue_ready;
  logic [ADDR_W-1:0] rd0_ctrl, rd1_ctrl;
  logic              rd0_hazard, rd1_hazard;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_w_ctrl;
  logic [DATA_W-1:0] rf_w_data;
  logic [ADDR_W:0]   busy_count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic                     lg;        // model: 1 = req1 granted last
  logic                     mg0, mg1;  // model grants of the current cycle

  regfile_wb_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .rd0_ctrl(rd0_ctrl), .rd1_ctrl(rd1_ctrl),
    .rd0_hazard(rd0_hazard), .rd1_hazard(rd1_hazard),
    .rf_write(rf_write), .rf_w_ctrl(rf_w_ctrl), .rf_w_data(rf_w_data),
    .busy_count(busy_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; issue_valid = 0;
    req0_addr = '0; req1_addr = '0; issue_addr = '0;
    req0_data = '0; req1_data = '0;
    exp_q.delete();
    lg = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                       input logic iv, input logic [ADDR_W-1:0] ia);
    @(negedge clk);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    issue_valid = iv; issue_addr = ia;
    mg0 = v0 && (!v1 || lg);
    mg1 = v1 && (!v0 || !lg);
    if (mg0) begin
      exp_q.push_back({a0, d0});
      lg = 1'b0;
    end else if (mg1) begin
      exp_q.push_back({a1, d1});
      lg = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W-1:0] e;
    if (rst_n && rf_write) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL wb_unexpected: got write ctrl=%0d data=%h, required no write", rf_w_ctrl, rf_w_data);
      end else begin
        e = exp_q.pop_front();
        if ({rf_w_ctrl, rf_w_data} !== e)
          begin
            tests_failed++;
            $display("FAIL wb_data: got ctrl=%0d data=%h, required ctrl=%0d data=%h",
                     rf_w_ctrl, rf_w_data, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
          end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    tests_run++;
    if ({rf_write, rf_w_ctrl, rf_w_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_wb: got write=%b ctrl=%0d data=%h, required all 0", rf_write, rf_w_ctrl, rf_w_data);
    end
    tests_run++;
    if (busy_count !== 0 || rd0_hazard !== 1'b0 || rd1_hazard !== 1'b0 || issue_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_sb: got count=%0d hz=%b%b ir=%b, required 0 00 1", busy_count, rd0_hazard, rd1_hazard, issue_ready);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 5'd3, 32'h11, 1'b0, '0, '0, 1'b0, '0);
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_ready: got r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
    end
    idle();
    tests_run++;
    if (rf_write !== 1'b1 || rf_w_ctrl !== 5'd3 || rf_w_data !== 32'h11) begin
      tests_failed++;
      $display("FAIL single_wb: got write=%b ctrl=%0d data=%h, required 1 3 00000011", rf_write, rf_w_ctrl, rf_w_data);
    end
    idle();
    tests_run++;
    if (rf_write !== 1'b0 || rf_w_ctrl !== 5'd3 || rf_w_data !== 32'h11) begin
      tests_failed++;
      $display("FAIL single_hold: got write=%b ctrl=%0d data=%h, required 0 3 00000011", rf_write, rf_w_ctrl, rf_w_data);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 1'b0, '0);
      tests_run++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: got r0=%b r1=%b, required r0=%b", i, req0_ready, req1_ready, (i % 2 == 0));
      end
      if (i > 0) begin
        tests_run++;
        if (rf_write !== 1'b1 || rf_w_ctrl !== ((i % 2 == 1) ? 5'd1 : 5'd2)) begin
          tests_failed++;
          $display("FAIL rr_wb%0d: got write=%b ctrl=%0d, required 1 %0d", i, rf_write, rf_w_ctrl, (i % 2 == 1) ? 1 : 2);
        end
      end
    end
    idle();
    tests_run++;
    if (rf_write !== 1'b1 || rf_w_ctrl !== 5'd2) begin
      tests_failed++;
      $display("FAIL rr_last: got write=%b ctrl=%0d, required 1 2", rf_write, rf_w_ctrl);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    rd0_ctrl = 5'd5;
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd5);
    tests_run++;
    if (issue_ready !== 1'b1 || rd0_hazard !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_issue: got ir=%b hz=%b, required 1 0", issue_ready, rd0_hazard);
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd5);
    tests_run++;
    if (issue_ready !== 1'b0 || rd0_hazard !== 1'b1 || busy_count !== 1) begin
      tests_failed++;
      $display("FAIL sb_busy: got ir=%b hz=%b count=%0d, required 0 1 1", issue_ready, rd0_hazard, busy_count);
    end
    drive(1'b0, '0, '0, 1'b1, 5'd5, 32'h55, 1'b0, '0);
    tests_run++;
    if (req1_ready !== 1'b1 || rd0_hazard !== 1'b1) begin
      tests_failed++;
      $display("FAIL sb_req1: got r1=%b hz=%b, required 1 1", req1_ready, rd0_hazard);
    end
    idle();
    tests_run++;
    if (rf_write !== 1'b1 || rd0_hazard !== 1'b1 || busy_count !== 1) begin
      tests_failed++;
      $display("FAIL sb_wbcycle: got write=%b hz=%b count=%0d, required 1 1 1", rf_write, rd0_hazard, busy_count);
    end
    idle();
    tests_run++;
    if (rd0_hazard !== 1'b0 || busy_count !== 0 || issue_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL sb_cleared: got hz=%b count=%0d ir=%b, required 0 0 1", rd0_hazard, busy_count, issue_ready);
    end
    rd0_ctrl = '0;
  endtask

  task automatic test_stray_write();
    rd1_ctrl = 5'd7;
    drive(1'b1, 5'd7, 32'h77, 1'b0, '0, '0, 1'b0, '0);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
    tests_run++;
    if (rf_write !== 1'b1 || rf_w_ctrl !== 5'd7 || issue_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL stray_setup: got write=%b ctrl=%0d ir=%b, required 1 7 1", rf_write, rf_w_ctrl, issue_ready);
    end
    idle();
    tests_run++;
    if (rd1_hazard !== 1'b1 || busy_count !== 1) begin
      tests_failed++;
      $display("FAIL stray_setwins: got hz=%b count=%0d, required 1 1", rd1_hazard, busy_count);
    end
    drive(1'b1, 5'd7, 32'h78, 1'b0, '0, '0, 1'b0, '0);
    idle();
    idle();
    tests_run++;
    if (rd1_hazard !== 1'b0 || busy_count !== 0) begin
      tests_failed++;
      $display("FAIL stray_clear: got hz=%b count=%0d, required 0 0", rd1_hazard, busy_count);
    end
    rd1_ctrl = '0;
  endtask

  task automatic test_async_reset();
    rd0_ctrl = 5'd10;
    rd1_ctrl = 5'd13;
    for (int i = 10; i < 13; i++)
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'(i));
    drive(1'b1, 5'd20, 32'hCAFE, 1'b0, '0, '0, 1'b1, 5'd13);
    idle();
    tests_run++;
    if (rf_write !== 1'b1 || busy_count !== 4 || rd0_hazard !== 1'b1 || rd1_hazard !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_pre: got write=%b count=%0d hz=%b%b, required 1 4 11", rf_write, busy_count, rd0_hazard, rd1_hazard);
    end
    #2;
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; issue_valid = 0;
    exp_q.delete();
    lg = 1'b1;
    #1;
    tests_run++;
    if (rf_write !== 1'b0 || busy_count !== 0 || rd0_hazard !== 1'b0 || rd1_hazard !== 1'b0 || rf_w_ctrl !== 0) begin
      tests_failed++;
      $display("FAIL areset_now: got write=%b count=%0d hz=%b%b ctrl=%0d, required 0 0 00 0",
               rf_write, busy_count, rd0_hazard, rd1_hazard, rf_w_ctrl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99, 1'b0, '0);
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_tie: got r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
    end
    idle();
    idle();
    rd0_ctrl = '0;
    rd1_ctrl = '0;
  endtask

  task automatic test_sweep();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < NREGS; i++) begin
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'(i));
      tests_run++;
      if (issue_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL sweep_issue%0d: got ir=%b, required 1", i, issue_ready);
      end
    end
    for (int i = 0; i < NREGS; i++) begin
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'(i));
      tests_run++;
      if (issue_ready !== 1'b0 || busy_count !== NREGS) begin
        tests_failed++;
        $display("FAIL sweep_full%0d: got ir=%b count=%0d, required 0 32", i, issue_ready, busy_count);
      end
    end
    for (int i = 0; i < NREGS; i++) begin
      d = $urandom_range(32'hFFFF_FFFF, 0);
      if (i % 2 == 0) drive(1'b1, 5'(i), d, 1'b0, '0, '0, 1'b0, '0);
      else            drive(1'b0, '0, '0, 1'b1, 5'(i), d, 1'b0, '0);
      tests_run++;
      if (((i % 2 == 0) ? req0_ready : req1_ready) !== 1'b1 ||
          busy_count !== ((i == 0) ? NREGS : NREGS + 1 - i)) begin
        tests_failed++;
        $display("FAIL sweep_retire%0d: got r0=%b r1=%b count=%0d, required count=%0d",
                 i, req0_ready, req1_ready, busy_count, (i == 0) ? NREGS : NREGS + 1 - i);
      end
    end
    idle();
    tests_run++;
    if (busy_count !== 1) begin
      tests_failed++;
      $display("FAIL sweep_tail1: got count=%0d, required 1", busy_count);
    end
    idle();
    tests_run++;
    if (busy_count !== 0 || issue_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL sweep_empty: got count=%0d ir=%b, required 0 1", busy_count, issue_ready);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    rd0_ctrl = '0;
    rd1_ctrl = '0;
    lg = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_scoreboard();
    test_stray_write();
    test_async_reset();
    test_sweep();
    idle();
    idle();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL wb_missing: got %0d writes still expected, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
Schedules writeback into the 32-entry, 32-bit register file. Two producers compete for the single write port: req0 is the decode/ALU result path and req1 is the memory/load return path. The block arbitrates them round-robin and drives the file's write, w_ctrl and w_data inputs through a registered stage. It also keeps a busy scoreboard, so decode can stall reads of registers whose writeback is still pending.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width
NUM_REGS, 32, number of scoreboarded registers (2**ADDR_W)

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous, active-low reset
req0_valid  in  1  producer 0 has a writeback
req0_addr  in  ADDR_W  producer 0 destination register
req0_data  in  DATA_W  producer 0 result
req0_ready  out  1  producer 0 accepted this cycle
req1_valid  in  1  producer 1 has a writeback
req1_addr  in  ADDR_W  producer 1 destination register
req1_data  in  DATA_W  producer 1 result
req1_ready  out  1  producer 1 accepted this cycle
issue_valid  in  1  decode issues an instruction writing issue_addr
issue_addr  in  ADDR_W  destination to mark pending
issue_ready  out  1  issue accepted (destination not busy)
rd0_ctrl  in  ADDR_W  read-port-0 index used by decode
rd1_ctrl  in  ADDR_W  read-port-1 index used by decode
rd0_hazard  out  1  busy[rd0_ctrl]
rd1_hazard  out  1  busy[rd1_ctrl]
rf_write  out  1  register file write enable (registered)
rf_w_ctrl  out  ADDR_W  register file write index (registered)
rf_w_data  out  DATA_W  register file write data (registered)
busy_count  out  ADDR_W+1  number of set busy bits

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rf_write=0, rf_w_ctrl=0, rf_w_data=0.
  - All busy bits 0, busy_count=0.
  - last_grant=1, so req0 wins the first tie.
  - Takes effect immediately mid-operation; an in-flight rf_write is dropped, and producers must re-present after reset.
- Arbitration (combinational):
  - Only one valid: that producer is granted.
  - Both valid: the producer not in last_grant is granted.
  - Neither valid: no grant.
  - reqN_ready = grantN. At most one ready per cycle. A ready never asserts without its valid.
  - last_grant updates only on a grant.
- Handshake:
  - A transfer occurs on the posedge where valid & ready.
  - The producer holds valid/addr/data stable until ready.
  - There is no backpressure from the file, so a sole requester is accepted the same cycle it asserts valid.
- Write stage:
  - On a grant at edge N, rf_write=1, rf_w_ctrl=addr and rf_w_data=data during cycle N+1.
  - The register file commits at edge N+1.
  - With no grant, rf_write=0 and ctrl/data hold their previous values.
  - Back-to-back grants give rf_write=1 every cycle.
- Scoreboard:
  - issue_ready = ~busy[issue_addr].
  - On issue_valid & issue_ready at an edge, busy[issue_addr] is set.
  - The edge where rf_write=1 clears busy[rf_w_ctrl].
  - Same edge, same address for set and clear: the set wins.
  - A write to a non-busy register is legal; the clear is a no-op.
- Hazards:
  - rdN_hazard = busy[rdN_ctrl], combinational.
  - A hazard drops in the cycle after the committing edge, so decode reads the new value with no bypass.
- busy_count:
  - Registered; tracks the popcount of busy.
  - Simultaneous set and clear of different registers leaves it unchanged.
  - Never exceeds NUM_REGS.
- No combinational path from req*_data to any output.

Test Plan:
1. Reset, then req0 only (addr=3, data=0x11) for one cycle -> req0_ready=1 that cycle; next cycle rf_write=1, rf_w_ctrl=3, rf_w_data=0x11; following cycle rf_write=0.
2. Both valid continuously (req0 addr=1/data=0xA, req1 addr=2/data=0xB) -> grant order req0, req1, req0, req1; rf_write stays high and rf_w_ctrl alternates 1,2,1,2.
3. Issue addr=5, then hold rd0_ctrl=5 -> rd0_hazard=1 and busy_count=1. A second issue of addr=5 sees issue_ready=0. After req1 writes addr=5: hazard still 1 in the rf_write cycle, then 0, and busy_count=0.
4. Issue addr=7 on the same edge that rf_write commits addr=7 (stray write) -> busy[7] remains 1 and busy_count increments by 1.
5. Assert rst_n=0 asynchronously mid-cycle while rf_write=1 and busy_count=4 -> rf_write, busy_count and all hazards go 0 immediately, without waiting for a clock edge. After release, a tie is won by req0.
6. Sweep: issue all 32 registers, then retire them in order via alternating producers -> busy_count goes 32 down to 0 and issue_ready is low for each busy address.
